// File: rtl/nibble_seq_checker.sv
// nibble_seq_checker
//   Checks that successive 4-bit samples from the upstream loadable counter
//   stage follow a +1 mod 16 sequence. It has a three-state lock FSM
//   (HUNT -> SYNC -> LOCKED) and a saturating counter of mismatches seen
//   while locked.
//   Optional feature macro: NIBBLE_CHK_DOWN_EN. When it is defined, the
//   module gains a dir input: 0 checks the +1 sequence, 1 checks the -1
//   sequence.
// Ports:
//   clk      in   clock, posedge
//   reset    in   asynchronous active-low reset
//   en       in   sample valid
//   din[3:0] in   sample under test
//   clr      in   synchronous clear of err_cnt (wins over an increment)
//   dir      in   direction select (only with NIBBLE_CHK_DOWN_EN)
//   locked   out  FSM is in LOCKED
//   err_cnt  out  saturating mismatch count while locked
//   expected out  value the next sample must equal
//   mismatch out  one-cycle pulse per mismatching sample in LOCKED
module nibble_seq_checker #(
  parameter int unsigned LOCK_CNT   = 4,
  parameter int unsigned UNLOCK_CNT = 2,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [3:0]       din,
  input  logic             clr,
`ifdef NIBBLE_CHK_DOWN_EN
  input  logic             dir,
`endif
  output logic             locked,
  output logic [CNT_W-1:0] err_cnt,
  output logic [3:0]       expected,
  output logic             mismatch
);

  typedef enum logic [1:0] {HUNT, SYNC, LOCKED} state_t;

  localparam logic [3:0] LC = 4'(LOCK_CNT);
  localparam logic [3:0] UC = 4'(UNLOCK_CNT);

  state_t           r_state,  w_state_nxt;
  logic [3:0]       r_expected, w_exp_nxt;
  logic [3:0]       r_match_run, w_match_nxt;
  logic [3:0]       r_miss_run,  w_miss_nxt;
  logic [CNT_W-1:0] r_err_cnt,   w_err_nxt;
  logic             r_mismatch,  w_mm_nxt;
  logic [3:0]       w_step;     // +1 or -1 (4'hF) mod 16
  logic [3:0]       w_exp_eff;  // expected value in the current direction
  logic             w_match;

`ifdef NIBBLE_CHK_DOWN_EN
  // r_expected was built with the direction in force at the last accepted
  // sample. If dir has changed since, the last accepted value is
  // r_expected - old_step, so the new target is r_expected + 2*new_step.
  logic r_dir;
  assign w_step    = dir ? 4'hF : 4'h1;
  assign w_exp_eff = (dir != r_dir) ? (r_expected + w_step + w_step) : r_expected;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)  r_dir <= 1'b0;
    else if (en) r_dir <= dir;
  end
`else
  assign w_step    = 4'h1;
  assign w_exp_eff = r_expected;
`endif

  assign w_match = (din == w_exp_eff);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= HUNT;
      r_expected  <= '0;
      r_match_run <= '0;
      r_miss_run  <= '0;
      r_err_cnt   <= '0;
      r_mismatch  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_expected  <= w_exp_nxt;
      r_match_run <= w_match_nxt;
      r_miss_run  <= w_miss_nxt;
      r_err_cnt   <= w_err_nxt;
      r_mismatch  <= w_mm_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_exp_nxt   = r_expected;
    w_match_nxt = r_match_run;
    w_miss_nxt  = r_miss_run;
    w_err_nxt   = r_err_cnt;
    w_mm_nxt    = 1'b0;
    if (en) begin
      unique case (r_state)
        HUNT: begin
          w_exp_nxt   = din + w_step;
          w_match_nxt = '0;
          w_state_nxt = SYNC;
        end
        SYNC: begin
          w_exp_nxt = din + w_step;
          if (w_match) begin
            w_match_nxt = r_match_run + 4'd1;
            if (r_match_run + 4'd1 == LC) begin
              w_state_nxt = LOCKED;
              w_miss_nxt  = '0;
            end
          end else begin
            w_match_nxt = '0;
          end
        end
        LOCKED: begin
          w_exp_nxt = w_exp_eff + w_step;
          if (w_match) begin
            w_miss_nxt = '0;
          end else begin
            // Flywheel: the bad sample is dropped and the sequence coasts.
            w_mm_nxt   = 1'b1;
            w_miss_nxt = r_miss_run + 4'd1;
            if (r_err_cnt != '1) w_err_nxt = r_err_cnt + CNT_W'(1);
            if (r_miss_run + 4'd1 == UC) w_state_nxt = HUNT;
          end
        end
        default: w_state_nxt = HUNT;
      endcase
    end
    if (clr) w_err_nxt = '0;
  end

  assign locked   = (r_state == LOCKED);
  assign err_cnt  = r_err_cnt;
  assign expected = r_expected;
  assign mismatch = r_mismatch;

endmodule
